// File: rtl/mem_arbiter.sv
// Fetch/data arbiter sharing one single-ported memory; data has priority.
// Define MEM_ARB_STARVE_GUARD_EN to bound fetch latency under data pressure.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int AW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_rvalid,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [AW-1:0]     m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_be,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata,
  output logic [1:0]        owner
);

  localparam int BW = XLEN / 8;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_chk
    $error("mem_arbiter: STARVE_LIMIT must be 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic [XLEN-1:0]   m_wdata_q, m_wdata_d;
  logic [BW-1:0]     m_be_q, m_be_d;
  logic [1:0]        owner_q, owner_d;
  logic              any_req;
  logic              pick_d;
  logic              resp;

  assign any_req = if_req | d_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  // Fetch overrides data once it has watched LIMIT data grants go by.
  assign pick_d = d_req & ~(if_req & (starve_q == LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE && any_req) begin
      if (!pick_d) starve_d = '0;
      else if (if_req) starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      owner_q   <= OWN_NONE;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
      owner_q   <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    owner_d   = owner_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ISSUE;
          m_req_d = 1'b1;
          if (pick_d) begin
            owner_d   = OWN_D;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_be;
          end else begin
            owner_d  = OWN_IF;
            m_we_d   = 1'b0;
            m_addr_d = if_addr;
            m_be_d   = '0;
          end
        end
      end
      S_ISSUE: begin
        if (m_ready) begin
          state_d = S_WAIT;
          m_req_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (m_rvalid) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Responses only count in WAIT; anything else is stale.
  always_comb begin
    resp      = (state_q == S_WAIT) & m_rvalid;
    if_rvalid = resp & (owner_q == OWN_IF);
    d_rvalid  = resp & (owner_q == OWN_D);
    if_rdata  = if_rvalid ? m_rdata : '0;
    d_rdata   = d_rvalid ? m_rdata : '0;
    if_stall  = if_req & ~if_rvalid;
    d_stall   = d_req & ~d_rvalid;
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_be    = m_be_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter.
// Memory and arbitration rules are modelled at transaction level.
module tb_mem_arbiter;

  localparam int LIM = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_rvalid, if_stall;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_rdata;
  logic        d_rvalid, d_stall;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ready = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  owner;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32), .AW(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .owner(owner)
  );

  task automatic clr();
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_be = 0;
    m_ready = 0; m_rvalid = 0; m_rdata = 0;
  endtask

  task automatic drv();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr();
    reset = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1;
  endtask

  task automatic test_reset();
    clr();
    m_rvalid = 1;
    reset = 0;
    #3;
    total++;
    if ({m_req, m_we, m_addr, m_wdata, m_be, owner} !== '0) begin
      bad++;
      $display("FAIL rst_mregs: got %h want 0",
               {m_req, m_we, m_addr, m_wdata, m_be, owner});
    end
    total++;
    if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== '0) begin
      bad++;
      $display("FAIL rst_resp: got %h want 0",
               {if_rvalid, d_rvalid, if_rdata, d_rdata});
    end
    do_reset();
  endtask

  task automatic test_single_fetch();
    drv();
    if_req = 1; if_addr = 32'h40; m_ready = 1;
    @(negedge clk);
    total++;
    if ({if_stall, m_req, owner} !== 4'b1_0_00) begin
      bad++;
      $display("FAIL sf_c0: got %b want 1000", {if_stall, m_req, owner});
    end
    drv();
    @(negedge clk);
    total++;
    if ({m_req, owner, m_we, if_rvalid} !== 5'b1_01_0_0) begin
      bad++;
      $display("FAIL sf_issue: got %b want 10100",
               {m_req, owner, m_we, if_rvalid});
    end
    total++;
    if (m_addr !== 32'h40) begin
      bad++;
      $display("FAIL sf_addr: got %h want 40", m_addr);
    end
    drv();
    m_rvalid = 1; m_rdata = 32'h0050_0093;
    @(negedge clk);
    total++;
    if ({if_rvalid, if_stall, m_req, d_rvalid, owner} !== 6'b1_0_0_0_01) begin
      bad++;
      $display("FAIL sf_resp: got %b want 100001",
               {if_rvalid, if_stall, m_req, d_rvalid, owner});
    end
    total++;
    if (if_rdata !== 32'h0050_0093) begin
      bad++;
      $display("FAIL sf_rdata: got %h want 00500093", if_rdata);
    end
    drv();
    if_req = 0; m_rvalid = 0;
    @(negedge clk);
    total++;
    if ({owner, if_rvalid, m_req, if_rdata} !== '0) begin
      bad++;
      $display("FAIL sf_idle: got %h want 0",
               {owner, if_rvalid, m_req, if_rdata});
    end
  endtask

  task automatic test_priority();
    drv();
    if_req = 1; if_addr = 32'h44;
    d_req = 1; d_we = 0; d_addr = 32'h100; m_ready = 1;
    @(negedge clk);
    total++;
    if ({if_stall, d_stall, m_req} !== 3'b110) begin
      bad++;
      $display("FAIL pr_c0: got %b want 110", {if_stall, d_stall, m_req});
    end
    drv();
    m_rvalid = 1; m_rdata = 32'h1111_2222;
    @(negedge clk);
    total++;
    if ({m_req, owner, m_we, d_rvalid, if_stall} !== 6'b1_10_0_0_1) begin
      bad++;
      $display("FAIL pr_issue: got %b want 110001",
               {m_req, owner, m_we, d_rvalid, if_stall});
    end
    total++;
    if (m_addr !== 32'h100) begin
      bad++;
      $display("FAIL pr_addr: got %h want 100", m_addr);
    end
    drv();
    m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if ({d_rvalid, d_stall, if_rvalid, if_stall} !== 4'b1001) begin
      bad++;
      $display("FAIL pr_dresp: got %b want 1001",
               {d_rvalid, d_stall, if_rvalid, if_stall});
    end
    total++;
    if ({d_rdata, if_rdata} !== {32'hDEAD_BEEF, 32'h0}) begin
      bad++;
      $display("FAIL pr_drdata: got %h want deadbeef", d_rdata);
    end
    drv();
    d_req = 0; m_rvalid = 0;
    @(negedge clk);
    total++;
    if ({owner, m_req, if_stall} !== 4'b00_0_1) begin
      bad++;
      $display("FAIL pr_gap: got %b want 0001", {owner, m_req, if_stall});
    end
    drv();
    @(negedge clk);
    total++;
    if ({m_req, owner, m_addr, if_stall} !== {1'b1, 2'b01, 32'h44, 1'b1}) begin
      bad++;
      $display("FAIL pr_fissue: got %b %b %h want 1 01 44",
               m_req, owner, m_addr);
    end
    drv();
    m_rvalid = 1; m_rdata = 32'h0000_0013;
    @(negedge clk);
    total++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h13}) begin
      bad++;
      $display("FAIL pr_fresp: got %b %h want 1 13", if_rvalid, if_rdata);
    end
    drv();
    if_req = 0; m_rvalid = 0;
    @(negedge clk);
  endtask

  task automatic test_store_stall();
    drv();
    d_req = 1; d_we = 1; d_addr = 32'h200;
    d_wdata = 32'h1234_5678; d_be = 4'b0011; m_ready = 0;
    @(negedge clk);
    total++;
    if ({d_stall, m_req} !== 2'b10) begin
      bad++;
      $display("FAIL st_c0: got %b want 10", {d_stall, m_req});
    end
    for (int k = 0; k < 4; k++) begin
      drv();
      m_ready = (k == 3);
      @(negedge clk);
      total++;
      if ({m_req, m_we, owner, m_be, d_rvalid, d_stall} !== 10'b1_1_10_0011_0_1 ||
          m_addr !== 32'h200 || m_wdata !== 32'h1234_5678) begin
        bad++;
        $display("FAIL st_hold%0d: got %b %h %h want 1110001101 200 12345678",
                 k, {m_req, m_we, owner, m_be, d_rvalid, d_stall},
                 m_addr, m_wdata);
      end
    end
    drv();
    m_ready = 0; m_rvalid = 1; m_rdata = 32'hFFFF_0000;
    @(negedge clk);
    total++;
    if ({d_rvalid, d_stall, m_req} !== 3'b100) begin
      bad++;
      $display("FAIL st_ack: got %b want 100", {d_rvalid, d_stall, m_req});
    end
    drv();
    clr();
    @(negedge clk);
    total++;
    if ({owner, m_we, m_be, m_addr} !== {2'b00, 1'b1, 4'b0011, 32'h200}) begin
      bad++;
      $display("FAIL st_keep: got %b %b %b %h want 00 1 0011 200",
               owner, m_we, m_be, m_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    drv();
    if_req = 1; if_addr = 32'h80; m_ready = 1;
    drv();
    drv();
    @(negedge clk);
    total++;
    if ({m_req, owner, if_rvalid} !== 4'b0_01_0) begin
      bad++;
      $display("FAIL rw_wait: got %b want 0010", {m_req, owner, if_rvalid});
    end
    #2;
    reset = 0; if_req = 0;
    #1;
    total++;
    if ({m_req, m_we, m_addr, m_wdata, m_be, owner, if_rvalid,
         d_rvalid, if_rdata, d_rdata, if_stall, d_stall} !== '0) begin
      bad++;
      $display("FAIL rw_async: got owner=%b addr=%h want 0", owner, m_addr);
    end
    drv();
    reset = 1; m_rvalid = 1; m_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    total++;
    if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== '0) begin
      bad++;
      $display("FAIL rw_stale: got %b%b want 00", if_rvalid, d_rvalid);
    end
    drv();
    m_rvalid = 0;
    @(negedge clk);
    total++;
    if ({m_req, owner} !== 3'b0) begin
      bad++;
      $display("FAIL rw_idle: got %b want 000", {m_req, owner});
    end
  endtask

  task automatic test_starvation();
    logic [1:0] got[$];
    logic [1:0] exp;
    int c;
    do_reset();
    drv();
    if_req = 1; if_addr = 32'h50;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    m_ready = 1; m_rvalid = 1; m_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 40 && got.size() < 6; k++) begin
      @(negedge clk);
      if (m_req) got.push_back(owner);
      drv();
    end
    total++;
    if (got.size() != 6) begin
      bad++;
      $display("FAIL sv_timeout: got %0d grants want 6", got.size());
    end
    c = 0;
    for (int k = 0; k < 6; k++) begin
      if (GUARD && c == LIM) begin
        exp = 2'b01; c = 0;
      end else begin
        exp = 2'b10; c++;
      end
      total++;
      if (k >= got.size() || got[k] !== exp) begin
        bad++;
        $display("FAIL sv_order%0d: got %b want %b", k,
                 (k < got.size()) ? got[k] : 2'bxx, exp);
      end
    end
    clr();
    m_ready = 1; m_rvalid = 1;
    repeat (4) drv();
    clr();
  endtask

  task automatic test_random();
    logic [31:0] mem[16];
    logic [31:0] f_addr, d_ad, d_wd, c_addr, c_wd, rd;
    logic [3:0]  d_b, c_be;
    logic [1:0]  c_own;
    logic        f_pend, d_pend, dwe, c_we, resp, exp_i, exp_d, take_d;
    int ph, dly, cnt;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    f_pend = 0; d_pend = 0; dwe = 0; c_we = 0;
    f_addr = 0; d_ad = 0; d_wd = 0; d_b = 0;
    c_addr = 0; c_wd = 0; c_be = 0; c_own = 0;
    ph = 0; dly = 0; cnt = 0;
    for (int cy = 0; cy < 500; cy++) begin
      drv();
      if (!f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1;
        f_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1;
        dwe = 1'($urandom_range(0, 1));
        d_ad = 32'($urandom_range(0, 15)) << 2;
        d_wd = $urandom;
        d_b = 4'($urandom_range(1, 15));
      end
      if_req = f_pend; if_addr = f_addr;
      d_req = d_pend; d_we = dwe; d_addr = d_ad;
      d_wdata = d_wd; d_be = d_b;
      m_ready = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
      m_rvalid = 0;
      if (ph == 2 && dly == 0) begin
        m_rvalid = 1;
        if (!c_we) m_rdata = mem[c_addr[5:2]];
      end else if (ph != 2 && $urandom_range(0, 4) == 0) begin
        m_rvalid = 1;
      end
      rd = m_rdata;
      @(negedge clk);
      resp = (ph == 2) && m_rvalid;
      exp_i = resp && c_own == 2'b01;
      exp_d = resp && c_own == 2'b10;
      total++;
      if (m_req !== (ph == 1)) begin
        bad++;
        $display("FAIL rnd_mreq@%0d: got %b want %b", cy, m_req, ph == 1);
      end
      total++;
      if (ph == 0 && owner !== 2'b00) begin
        bad++;
        $display("FAIL rnd_owner_idle@%0d: got %b want 00", cy, owner);
      end else if (ph != 0 && {owner, m_addr, m_we} !== {c_own, c_addr, c_we}) begin
        bad++;
        $display("FAIL rnd_fields@%0d: got %b %h %b want %b %h %b",
                 cy, owner, m_addr, m_we, c_own, c_addr, c_we);
      end
      if (ph != 0 && c_own == 2'b10) begin
        total++;
        if ({m_wdata, m_be} !== {c_wd, c_be}) begin
          bad++;
          $display("FAIL rnd_wfields@%0d: got %h %b want %h %b",
                   cy, m_wdata, m_be, c_wd, c_be);
        end
      end
      total++;
      if ({if_rvalid, d_rvalid} !== {exp_i, exp_d}) begin
        bad++;
        $display("FAIL rnd_rvalid@%0d: got %b%b want %b%b",
                 cy, if_rvalid, d_rvalid, exp_i, exp_d);
      end
      total++;
      if (if_rdata !== (exp_i ? rd : 32'h0)) begin
        bad++;
        $display("FAIL rnd_ifrdata@%0d: got %h want %h",
                 cy, if_rdata, exp_i ? rd : 32'h0);
      end
      if (!(exp_d && c_we)) begin
        total++;
        if (d_rdata !== (exp_d ? rd : 32'h0)) begin
          bad++;
          $display("FAIL rnd_drdata@%0d: got %h want %h",
                   cy, d_rdata, exp_d ? rd : 32'h0);
        end
      end
      total++;
      if ({if_stall, d_stall} !== {f_pend & ~exp_i, d_pend & ~exp_d}) begin
        bad++;
        $display("FAIL rnd_stall@%0d: got %b%b want %b%b", cy,
                 if_stall, d_stall, f_pend & ~exp_i, d_pend & ~exp_d);
      end
      case (ph)
        0: if (f_pend || d_pend) begin
          take_d = d_pend && !(GUARD && f_pend && cnt == LIM);
          if (take_d) begin
            c_own = 2'b10; c_we = dwe; c_addr = d_ad;
            c_wd = d_wd; c_be = d_b;
            if (f_pend) cnt++;
          end else begin
            c_own = 2'b01; c_we = 0; c_addr = f_addr;
            cnt = 0;
          end
          ph = 1;
        end
        1: if (m_ready) begin
          ph = 2;
          dly = $urandom_range(0, 2);
        end
        default: if (resp) begin
          if (c_we)
            for (int b = 0; b < 4; b++)
              if (c_be[b]) mem[c_addr[5:2]][8*b +: 8] = c_wd[8*b +: 8];
          if (c_own == 2'b01) f_pend = 0;
          else d_pend = 0;
          ph = 0;
        end else begin
          dly--;
        end
      endcase
    end
    drv();
    clr();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_store_stall();
    test_reset_in_wait();
    test_starvation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that lets the core's instruction-fetch stage and load/store unit share one single-ported unified memory. It sits between the 3-stage pipeline and the memory inside `main`. It sequences each access through a request/accept/response handshake and produces per-requester stall signals for the hazard logic. Data accesses have priority, and an optional starvation guard bounds fetch latency.

## Interface
- `XLEN`, 32: data width; also sets byte-enable width `XLEN/8`.
- `AW`, 32: address width.
- `STARVE_LIMIT`, 4: number of consecutive data grants tolerated while a fetch waits. Legal range 1..15.

- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_rvalid`.
- `if_addr` in AW: fetch address.
- `if_rdata` out XLEN: fetch data; equals `m_rdata` when `if_rvalid`=1, else 0.
- `if_rvalid` out 1: fetch complete.
- `if_stall` out 1: `if_req & ~if_rvalid`.
- `d_req` in 1: data request; held with all `d_*` stable until `d_rvalid`.
- `d_we` in 1: 1 = store.
- `d_addr` in AW; `d_wdata` in XLEN; `d_be` in XLEN/8: store byte enables.
- `d_rdata` out XLEN: load data; equals `m_rdata` when `d_rvalid`=1, else 0.
- `d_rvalid` out 1: load data valid or store acknowledged.
- `d_stall` out 1: `d_req & ~d_rvalid`.
- `m_req` out 1: memory request (registered).
- `m_we` out 1; `m_addr` out AW; `m_wdata` out XLEN; `m_be` out XLEN/8: registered request fields.
- `m_ready` in 1: memory accepts when `m_req & m_ready`.
- `m_rvalid` in 1: response or write ack, one per accepted request.
- `m_rdata` in XLEN: read data.
- `owner` out 2: 00 idle, 01 fetch, 10 data.

## Operation
- FSM states:
  - IDLE: no access in progress; arbitrates pending requests.
  - ISSUE: `m_req`=1 with the latched request; waits for `m_ready`.
  - WAIT: waits for `m_rvalid`.
- IDLE:
  - Arbitrate among asserted requests; the winner's fields are latched into the `m_*` registers, `owner` is set, and the FSM goes to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: `m_req`=1. On `m_req & m_ready`, go to WAIT and clear `m_req`. Any `m_rvalid` seen in ISSUE is ignored.
- WAIT:
  - On `m_rvalid`, assert the owner's rvalid combinationally in the same cycle, gate `m_rdata` to the owner's rdata, and return to IDLE next cycle.
  - On that IDLE edge, `owner` becomes 00 and `m_we`/`m_addr`/`m_wdata`/`m_be` hold their last values.
- Priority: data beats fetch when both are pending, because the data access belongs to the older instruction.
- A requester still asserting `req` in the cycle after its rvalid is treated as a new request.
- `m_rvalid` in IDLE is ignored; it is a stale response after reset.
- Store: `m_we`=1 and `m_be`=`d_be`. `d_rvalid` acks the store, and `d_rdata` is don't-care during a store ack.

## Timing
- Reset (async assert, sync release):
  - FSM returns to IDLE.
  - `m_req`, `m_we`, `m_addr`, `m_wdata`, `m_be`, and `owner` are 0.
  - `if_rvalid`, `d_rvalid`, `if_rdata`, and `d_rdata` are 0.
  - Starvation counter is 0.
  - An in-flight access is abandoned and its late response is discarded.
- Minimum latency with `m_ready`=1 and `m_rvalid` on the cycle after accept:
  - request seen at edge N;
  - `m_req` high during cycle N..N+1;
  - rvalid in cycle N+1..N+2;
  - next grant possible at edge N+3.
- Back-to-back: the arbiter always passes through one IDLE cycle between accesses.
- `if_stall`/`d_stall` are high from `req` assertion until the cycle of the matching rvalid, inclusive of the waiting cycles, and exclusive of the rvalid cycle.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each data grant made while `if_req`=1, and clears on any fetch grant.
  - When the counter equals `STARVE_LIMIT` and both are pending, fetch wins.
- `MEM_ARB_STARVE_GUARD_EN` undefined: strict data priority; no counter logic.

## Test plan
- Single fetch, `if_addr`=0x40, memory returns 0x00500093 one cycle after accept:
  - `if_rvalid` asserts two cycles after the request is seen, with `if_rdata`=0x00500093.
  - `owner` sequence is 01 then 00.
- Simultaneous `if_req` and `d_req` (load 0x100 returning 0xDEADBEEF):
  - data is served first;
  - `if_stall` stays high throughout;
  - fetch issues after one IDLE cycle.
- Store `d_addr`=0x200, `d_wdata`=0x12345678, `d_be`=0011, with `m_ready` held low 3 cycles:
  - `m_req` and its fields are stable for 4 cycles, then `m_we`=1 and `m_be`=0011;
  - `d_rvalid` acks the store.
- Reset pulled low while in WAIT:
  - all outputs go to 0 immediately;
  - a subsequent `m_rvalid` in IDLE produces no requester rvalid.
- With the guard defined and `STARVE_LIMIT`=2, data and fetch requesting continuously: grant order is D, D, I, D, D, I.
- With the guard undefined, the same stimulus: fetch is never granted while `d_req` stays asserted.
